// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_if
// Description : Bundle between the Mini SRC control sequencer and the
//               datapath / register select logic.
//               master (sequencer): inputs ir, mem_ready, stop; drives
//                 register-select strobes, bus strobes, alu_op, Read/Write
//                 and run.
//               slave (datapath side): the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic        stop;

  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Cout;
  logic        Read, Write;
  logic [4:0]  alu_op;
  logic        run;

  modport master (
    input  ir, mem_ready, stop,
    output Gra, Grb, Grc, Rin, Rout, BAout,
           PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Cout, Read, Write, alu_op, run
  );

  modport slave (
    output ir, mem_ready, stop,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
           PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Cout, Read, Write, alu_op, run
  );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Hardwired Moore sequencer for the Mini SRC datapath. Each
//               instruction runs fetch (T0-T2) then execute (T3-T7).
// Ports       : clock    - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               bus      - control_unit_if.master (ir, mem_ready, stop in;
//                          all datapath strobes, alu_op, run out)
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
  parameter logic [4:0] ADDR_OP = 5'b00011
) (
  input  logic           clock,
  input  logic           reset_n,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state, next_state;
  logic       t1_seen;   // set after the first T1 cycle so PCin pulses once
  logic [4:0] opcode;
  logic       is_rr, is_imm, is_ldi, is_ld, is_st, is_mem;
  logic [4:0] imm_op;

  assign opcode = bus.ir[31:27];
  assign is_rr  = (opcode >= OP_ADD) && (opcode <= OP_SHL);
  assign is_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign is_ldi = (opcode == OP_LDI);
  assign is_ld  = (opcode == OP_LD);
  assign is_st  = (opcode == OP_ST);
  assign is_mem = is_ld || is_st;

  always_comb begin
    imm_op = OP_ADD;
    if (opcode == OP_ANDI) imm_op = OP_AND;
    if (opcode == OP_ORI)  imm_op = OP_OR;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_RST;
      t1_seen <= 1'b0;
    end else begin
      state   <= next_state;
      t1_seen <= (state == S_T1) && (next_state == S_T1);
    end
  end

  always_comb begin
    next_state  = state;
    bus.Gra     = 1'b0;  bus.Grb    = 1'b0;  bus.Grc   = 1'b0;
    bus.Rin     = 1'b0;  bus.Rout   = 1'b0;  bus.BAout = 1'b0;
    bus.PCout   = 1'b0;  bus.PCin   = 1'b0;  bus.IncPC = 1'b0;
    bus.MARin   = 1'b0;  bus.MDRin  = 1'b0;  bus.MDRout = 1'b0;
    bus.IRin    = 1'b0;  bus.Yin    = 1'b0;  bus.Zin   = 1'b0;
    bus.Zlowout = 1'b0;  bus.Cout   = 1'b0;
    bus.Read    = 1'b0;  bus.Write  = 1'b0;
    bus.alu_op  = 5'b00000;
    bus.run     = (state != S_RST) && (state != S_HALT);

    case (state)
      S_RST: next_state = S_T0;
      S_T0: begin
        // A halt request suppresses the fetch strobes entirely.
        if (bus.stop) begin
          next_state = S_HALT;
        end else begin
          bus.PCout  = 1'b1;
          bus.MARin  = 1'b1;
          bus.IncPC  = 1'b1;
          bus.Zin    = 1'b1;
          next_state = S_T1;
        end
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = !t1_seen;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        if (bus.mem_ready) next_state = S_T2;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        if (is_rr || is_imm || is_ldi || is_mem) next_state = S_T3;
        else if (opcode == OP_HALT)              next_state = S_HALT;
        else                                     next_state = S_T0;
      end
      S_T3: begin
        bus.Grb = 1'b1;
        bus.Yin = 1'b1;
        // ldi/ld/st use base-address semantics (r0 reads as zero).
        if (is_ldi || is_mem) bus.BAout = 1'b1;
        else                  bus.Rout  = 1'b1;
        next_state = S_T4;
      end
      S_T4: begin
        bus.Zin = 1'b1;
        if (is_rr) begin
          bus.Grc    = 1'b1;
          bus.Rout   = 1'b1;
          bus.alu_op = opcode;
        end else if (is_imm) begin
          bus.Cout   = 1'b1;
          bus.alu_op = imm_op;
        end else begin
          bus.Cout   = 1'b1;
          bus.alu_op = ADDR_OP;
        end
        next_state = S_T5;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (is_mem) begin
          bus.MARin  = 1'b1;
          next_state = S_T6;
        end else begin
          bus.Gra    = 1'b1;
          bus.Rin    = 1'b1;
          next_state = S_T0;
        end
      end
      S_T6: begin
        bus.MDRin = 1'b1;
        if (is_ld) begin
          bus.Read = 1'b1;
          if (bus.mem_ready) next_state = S_T7;
        end else begin
          // Read low steers the bus (store data) into MDR.
          bus.Gra    = 1'b1;
          bus.Rout   = 1'b1;
          next_state = S_T7;
        end
      end
      S_T7: begin
        if (is_ld) begin
          bus.MDRout = 1'b1;
          bus.Gra    = 1'b1;
          bus.Rin    = 1'b1;
          next_state = S_T0;
        end else begin
          bus.Write = 1'b1;
          if (bus.mem_ready) next_state = S_T0;
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

endmodule
`default_nettype wire
